// File: rtl/ecc_mem_pkg.sv
// Shared widths and FSM state encoding for the ECC codeword storage stage.
package ecc_mem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/ecc_code_array.sv
// DEPTH x CODE_W codeword register file: one write port, one async read port, async clear to all-zero.
module ecc_code_array
    import ecc_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CODE_W-1:0] rdata_c
);

    logic [CODE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/hamming_decoder.sv
// SECDED decoder: corrects single-bit errors, flags any detected error (single or double).
module hamming_decoder
    import ecc_mem_pkg::*;
(
    input  logic [CODE_W-1:0] code_in,
    output logic [DATA_W-1:0] data_out,
    output logic              error
);

    logic [3:0]        syn;
    logic              parity_all;
    logic [CODE_W-1:0] fix_mask;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syn = '0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (code_in[p]) syn = syn ^ 4'(p);
        end
        parity_all = ^code_in;
        // Odd overall parity with a valid syndrome means one flipped bit at that position.
        fix_mask = '0;
        if (parity_all && (syn != 4'd0) && (syn < 4'(CODE_W))) begin
            fix_mask = CODE_W'(1) << syn;
        end
        fixed    = code_in ^ fix_mask;
        data_out = {fixed[12], fixed[11], fixed[10], fixed[9],
                    fixed[7], fixed[6], fixed[5], fixed[3]};
        error    = parity_all | (syn != 4'd0);
    end

endmodule

// File: rtl/hamming_encoder.sv
// SECDED encoder: Hamming(12,8) in code[12:1] (parity at positions 1,2,4,8) plus overall parity in code[0].
module hamming_encoder
    import ecc_mem_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] code_out
);

    logic [CODE_W-1:1] h;

    always_comb begin
        h     = '0;
        h[3]  = data_in[0];
        h[5]  = data_in[1];
        h[6]  = data_in[2];
        h[7]  = data_in[3];
        h[9]  = data_in[4];
        h[10] = data_in[5];
        h[11] = data_in[6];
        h[12] = data_in[7];
        h[1]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6];
        h[2]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6];
        h[4]  = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7];
        h[8]  = data_in[4] ^ data_in[5] ^ data_in[6] ^ data_in[7];
    end

    assign code_out = {h, ^h};

endmodule

// File: rtl/ecc_mem_ctrl.sv
// ECC codeword storage controller: one request in flight, encode on write, decode on read,
// optional fault-injection mask, saturating error counter with last-error address.
module ecc_mem_ctrl
    import ecc_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [CODE_W-1:0]    req_inj_mask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_we,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_error,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr
);

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [CODE_W-1:0]     mask_q, mask_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0]     last_err_addr_q, last_err_addr_d;

    logic                  arr_we_c;
    logic [CODE_W-1:0]     enc_code_c;
    logic [CODE_W-1:0]     arr_rdata_c;
    logic [DATA_W-1:0]     dec_data_c;
    logic                  dec_error_c;
    logic                  err_evt_c;

    hamming_encoder u_enc (
        .data_in  (wdata_q),
        .code_out (enc_code_c)
    );

    ecc_code_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (arr_we_c),
        .waddr   (addr_q),
        .wdata   (enc_code_c ^ mask_q),
        .raddr   (addr_q),
        .rdata_c (arr_rdata_c)
    );

    hamming_decoder u_dec (
        .code_in  (code_q),
        .data_out (dec_data_c),
        .error    (dec_error_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_we_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mask_q          <= '0;
            code_q          <= '0;
            err_count_q     <= '0;
            last_err_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_we_q        <= rsp_we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            mask_q          <= mask_d;
            code_q          <= code_d;
            err_count_q     <= err_count_d;
            last_err_addr_q <= last_err_addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rsp_we_d        = rsp_we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mask_d          = mask_q;
        code_d          = code_q;
        err_count_d     = err_count_q;
        last_err_addr_d = last_err_addr_q;
        arr_we_c        = 1'b0;
        err_evt_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mask_d  = req_inj_mask;
                    state_d = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                arr_we_c = 1'b1;
                rsp_we_d = 1'b1;
                state_d  = RESP;
            end
            READ: begin
                code_d   = arr_rdata_c;
                rsp_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    err_evt_c = !rsp_we_q && dec_error_c;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);

        // A clear coinciding with an erroring handshake leaves exactly that one error counted.
        if (err_clr) begin
            err_count_d = err_evt_c ? ERR_CNT_W'(1) : '0;
        end else if (err_evt_c && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
        if (err_evt_c) begin
            last_err_addr_d = addr_q;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_we        = rsp_we_q;
    assign rsp_rdata     = rsp_we_q ? '0 : dec_data_c;
    assign rsp_error     = dec_error_c & ~rsp_we_q;
    assign err_count     = err_count_q;
    assign last_err_addr = last_err_addr_q;

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed, table-driven bench for ecc_mem_ctrl with hand-written stall, saturation and reset sequences.
module tb_ecc_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [12:0] req_inj_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        err_clr;
    logic [7:0]  err_count;
    logic [3:0]  last_err_addr;

    int checks;
    int failures;

    ecc_mem_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_inj_mask  (req_inj_mask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_we        (rsp_we),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .err_clr       (err_clr),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [12:0] mask;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_cnt;
        logic [3:0]  exp_last;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic transact(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                            input logic [12:0] mask, input logic clr,
                            output logic [7:0] rd, output logic er, output logic rwe,
                            output int lat);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wd;
        req_inj_mask = mask;
        rsp_ready    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd      = rsp_rdata;
        er      = rsp_error;
        rwe     = rsp_we;
        err_clr = clr;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        logic       rwe;
        int         lat;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_inj_mask = '0;
        rsp_ready    = 1'b0;
        err_clr      = 1'b0;

        //            we    addr   wdata  mask      rdata  err   cnt    last
        vecs[0]  = '{1'b0, 4'd3,  8'h00, 13'h0000, 8'h00, 1'b0, 8'd0, 4'd0};
        vecs[1]  = '{1'b1, 4'd5,  8'hA5, 13'h0000, 8'h00, 1'b0, 8'd0, 4'd0};
        vecs[2]  = '{1'b0, 4'd5,  8'h00, 13'h0000, 8'hA5, 1'b0, 8'd0, 4'd0};
        vecs[3]  = '{1'b1, 4'd2,  8'h3C, 13'h0001, 8'h00, 1'b0, 8'd0, 4'd0};
        vecs[4]  = '{1'b0, 4'd2,  8'h00, 13'h0000, 8'h3C, 1'b1, 8'd1, 4'd2};
        vecs[5]  = '{1'b1, 4'd9,  8'h5A, 13'h0008, 8'h00, 1'b0, 8'd1, 4'd2};
        vecs[6]  = '{1'b0, 4'd9,  8'h00, 13'h0000, 8'h5A, 1'b1, 8'd2, 4'd9};
        vecs[7]  = '{1'b1, 4'd15, 8'h00, 13'h0028, 8'h00, 1'b0, 8'd2, 4'd9};
        vecs[8]  = '{1'b0, 4'd15, 8'h00, 13'h0000, 8'h03, 1'b1, 8'd3, 4'd15};
        vecs[9]  = '{1'b1, 4'd0,  8'hFF, 13'h0000, 8'h00, 1'b0, 8'd3, 4'd15};
        vecs[10] = '{1'b0, 4'd0,  8'h00, 13'h0000, 8'hFF, 1'b0, 8'd3, 4'd15};
        vecs[11] = '{1'b1, 4'd5,  8'hC3, 13'h0000, 8'h00, 1'b0, 8'd3, 4'd15};
        vecs[12] = '{1'b0, 4'd5,  8'h00, 13'h0000, 8'hC3, 1'b0, 8'd3, 4'd15};

        #12;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_we",    32'(rsp_we),    32'd0);
        chk("reset_rdata",     32'(rsp_rdata), 32'h00);
        chk("reset_error",     32'(rsp_error), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_last_addr", 32'(last_err_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            transact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 1'b0, rd, er, rwe, lat);
            chk($sformatf("vec%0d_latency", i),   32'(lat), 32'd2);
            chk($sformatf("vec%0d_rsp_we", i),    32'(rwe), 32'(vecs[i].we));
            chk($sformatf("vec%0d_rdata", i),     32'(rd),  32'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_error", i),     32'(er),  32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_last_addr", i), 32'(last_err_addr), 32'(vecs[i].exp_last));
        end

        // Stalled read response: outputs hold and a competing write is not accepted.
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 4'd5;
        req_inj_mask = '0;
        rsp_ready    = 1'b0;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_wdata = 8'h11;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", c),     32'(rsp_rdata), 32'hC3);
            chk($sformatf("stall%0d_error", c),     32'(rsp_error), 32'd0);
            chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_release_rsp_valid", 32'(rsp_valid), 32'd0);
        transact(1'b0, 4'd5, 8'h00, 13'h0, 1'b0, rd, er, rwe, lat);
        chk("stall_no_accept_rdata", 32'(rd), 32'hC3);

        // Drive the counter to saturation with erroring reads of addr 2.
        for (int k = 0; k < 252; k++) begin
            transact(1'b0, 4'd2, 8'h00, 13'h0, 1'b0, rd, er, rwe, lat);
        end
        chk("sat_reach_ff", 32'(err_count), 32'hFF);
        transact(1'b0, 4'd9, 8'h00, 13'h0, 1'b0, rd, er, rwe, lat);
        chk("sat_hold_ff", 32'(err_count), 32'hFF);
        chk("sat_last_addr", 32'(last_err_addr), 32'd9);
        transact(1'b0, 4'd2, 8'h00, 13'h0, 1'b1, rd, er, rwe, lat);
        chk("clr_with_inc", 32'(err_count), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_alone", 32'(err_count), 32'd0);

        // Reset while the write to addr 7 is in progress.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_after_req_ready", 32'(req_ready), 32'd1);
        transact(1'b0, 4'd7, 8'h00, 13'h0, 1'b0, rd, er, rwe, lat);
        chk("rst_addr7_rdata", 32'(rd), 32'h00);
        chk("rst_addr7_error", 32'(er), 32'd0);
        transact(1'b0, 4'd5, 8'h00, 13'h0, 1'b0, rd, er, rwe, lat);
        chk("rst_addr5_cleared", 32'(rd), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
